// File: rtl/tdm_pkg.sv
// Shared constants, FSM state type and the cyclic slot search used by the
// 8-to-1 TDM multiplexer.
package tdm_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } tdm_state_e;

  // Returns {any, slot}: first requesting slot after ptr, wrapping round to ptr itself last.
  function automatic logic [SEL_W:0] next_slot(input logic [SEL_W-1:0] ptr,
                                               input logic [NCH-1:0]   req);
    logic [SEL_W:0]   r;
    logic [SEL_W-1:0] idx;
    r = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Combinational cyclic priority finder: nearest requesting channel after ptr,
// with ptr itself as the lowest-priority candidate.
module rr_next_sel
  import tdm_pkg::*;
(
  input  logic [SEL_W-1:0] ptr,
  input  logic [NCH-1:0]   req,
  output logic [SEL_W-1:0] nxt,
  output logic             any
);

  assign {any, nxt} = next_slot(ptr, req);

endmodule

// File: rtl/tdm_mux_8to1.sv
// Registered 8-to-1 TDM multiplexer emitting one channel word plus slot index per clock.
// Define TDM_SKIP_IDLE_EN to compact the scan onto requesting channels only.
module tdm_mux_8to1
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NCH*DATA_W-1:0] i,
  input  logic [NCH-1:0]        req,
  output logic [DATA_W-1:0]     y,
  output logic [SEL_W-1:0]      s,
  output logic                  valid,
  output logic                  frame,
  output tdm_state_e            dbg_state
);

  // Handshake: valid=1 marks y/s as a requested beat; the sink has no ready and
  // must accept every cycle. frame marks the first beat of each frame.
  tdm_state_e        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [SEL_W-1:0]  s_q, s_d;
  logic              valid_q, valid_d;
  logic              frame_q, frame_d;

`ifdef TDM_SKIP_IDLE_EN
  // first_q: next beat is the first after IDLE, so search starts at slot 0 and it always pulses frame.
  logic              first_q, first_d;
  logic [SEL_W-1:0]  base;
  logic [SEL_W-1:0]  nxt;
  logic              any;
  logic              wrap;

  assign base = first_q ? SEL_W'(NCH - 1) : ptr_q;
  assign wrap = first_q || (nxt <= s_q);

  rr_next_sel u_rr (
    .ptr (base),
    .req (req),
    .nxt (nxt),
    .any (any)
  );
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    y_d     = y_q;
    s_d     = s_q;
    valid_d = 1'b0;
    frame_d = 1'b0;
`ifdef TDM_SKIP_IDLE_EN
    first_d = first_q;
`endif
    case (state_q)
      IDLE: begin
        ptr_d = '0;
        if (en) begin
          state_d = SCAN;
`ifdef TDM_SKIP_IDLE_EN
          first_d = 1'b1;
`endif
        end
      end
      default: begin
`ifdef TDM_SKIP_IDLE_EN
        // A wrap opens a new frame, so stopping here leaves the previous frame whole.
        if (any) begin
          if (wrap && !first_q && !en) begin
            state_d = IDLE;
            ptr_d   = '0;
          end else begin
            y_d     = i[nxt*DATA_W +: DATA_W];
            s_d     = nxt;
            valid_d = 1'b1;
            frame_d = wrap;
            ptr_d   = nxt;
            first_d = 1'b0;
          end
        end
`else
        y_d     = i[ptr_q*DATA_W +: DATA_W];
        s_d     = ptr_q;
        valid_d = req[ptr_q];
        frame_d = (ptr_q == '0);
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == SEL_W'(NCH - 1) && !en) state_d = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      y_q     <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
`ifdef TDM_SKIP_IDLE_EN
      first_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
`ifdef TDM_SKIP_IDLE_EN
      first_q <= first_d;
`endif
    end
  end

  assign y         = y_q;
  assign s         = s_q;
  assign valid     = valid_q;
  assign frame     = frame_q;
  assign dbg_state = state_q;

endmodule
